// File: rtl/multi_sphere_trace_seq_pkg.sv
// rtl/multi_sphere_trace_seq_pkg.sv - shared types, defaults and FSM encoding for the ray-trace sequencer
package multi_sphere_trace_seq_pkg;

  typedef logic [9:0]  vector;
  typedef logic [31:0] fixed_real;
  typedef logic [23:0] color;

  localparam fixed_real T_MAX_DEFAULT = 32'h8FFF0000;
  localparam int        H_RES_DEFAULT = 640;
  localparam int        V_RES_DEFAULT = 480;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAY_WAIT,
    ST_SPH_ISSUE,
    ST_SPH_WAIT,
    ST_WRITE,
    ST_ADVANCE,
    ST_DONE
  } seq_state_e;

  // A single sphere still needs a one-bit select port.
  function automatic int sidx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_sphere_trace_seq_if.sv
// rtl/multi_sphere_trace_seq_if.sv - collision-unit and frame-buffer handshake bundle
interface multi_sphere_trace_seq_if #(
  parameter int T_WIDTH = 32,
  parameter int SIDX_W  = 2
);
  import multi_sphere_trace_seq_pkg::*;

  vector               WriteX;
  vector               WriteY;
  logic [SIDX_W-1:0]   sph_idx;
  color                sph_col;
  logic                cd_req;
  logic [T_WIDTH-1:0]  cd_tbest;
  logic                cd_valid;
  logic                cd_collide;
  logic [T_WIDTH-1:0]  cd_tnew;
  logic                fb_we;
  logic                fb_ready;
  color                fb_color;

  modport master (
    output WriteX, WriteY, sph_idx, cd_req, cd_tbest, fb_we, fb_color,
    input  sph_col, cd_valid, cd_collide, cd_tnew, fb_ready
  );

  modport slave (
    input  WriteX, WriteY, sph_idx, cd_req, cd_tbest, fb_we, fb_color,
    output sph_col, cd_valid, cd_collide, cd_tnew, fb_ready
  );

endinterface

// File: rtl/multi_sphere_trace_seq_pixel_counter.sv
// rtl/multi_sphere_trace_seq_pixel_counter.sv - raster X/Y counter with clear, advance and last-pixel flag
module pixel_counter
  import multi_sphere_trace_seq_pkg::*;
#(
  parameter int H_RES = H_RES_DEFAULT,
  parameter int V_RES = V_RES_DEFAULT
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  en,
  output vector x,
  output vector y,
  output logic  last
);

  vector x_q, x_d;
  vector y_q, y_d;
  logic  x_end;
  logic  y_end;

  assign x_end = (x_q == vector'(H_RES - 1));
  assign y_end = (y_q == vector'(V_RES - 1));

  // Advancing from the last pixel wraps both axes back to the origin.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (!x_end) begin
        x_d = x_q + vector'(1);
      end else begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + vector'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = x_end && y_end;

endmodule

// File: rtl/multi_sphere_trace_seq.sv
// rtl/multi_sphere_trace_seq.sv - per-pixel sequencer: ray wait, closest-hit sphere loop, frame-buffer write
module multi_sphere_trace_seq
  import multi_sphere_trace_seq_pkg::*;
#(
  parameter int                 NUM_SPHERES = 4,
  parameter int                 H_RES       = H_RES_DEFAULT,
  parameter int                 V_RES       = V_RES_DEFAULT,
  parameter int                 T_WIDTH     = 32,
  parameter logic [T_WIDTH-1:0] T_MAX       = T_WIDTH'(T_MAX_DEFAULT),
  parameter int                 RAY_LAT     = 2,
  parameter color               BG_COLOR    = 24'h000000
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic start,
  output logic busy,
  output logic frame_done,
  multi_sphere_trace_seq_if.master bus
);

  localparam int SIDX_W = sidx_width(NUM_SPHERES);
  localparam int LAT_W  = $clog2(RAY_LAT + 1) + 1;
  localparam logic [LAT_W-1:0] LAT_LAST = (RAY_LAT > 1) ? LAT_W'(RAY_LAT - 1) : '0;

  seq_state_e          state_q, state_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [SIDX_W-1:0]   sph_idx_q, sph_idx_d;
  logic [T_WIDTH-1:0]  tbest_q, tbest_d;
  color                hit_col_q, hit_col_d;

  logic  pix_clr;
  logic  pix_en;
  logic  pix_last;
  logic  sph_last;
  logic  enter_ray;
  vector pix_x;
  vector pix_y;

  pixel_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_pixel_counter (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (pix_clr),
    .en    (pix_en),
    .x     (pix_x),
    .y     (pix_y),
    .last  (pix_last)
  );

  assign sph_last  = (sph_idx_q == SIDX_W'(NUM_SPHERES - 1));
  assign pix_clr   = (state_q == ST_IDLE) && start;
  assign pix_en    = (state_q == ST_ADVANCE);
  assign enter_ray = pix_clr || ((state_q == ST_ADVANCE) && !pix_last);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start) state_d = ST_RAY_WAIT;
      ST_RAY_WAIT:  if (lat_cnt_q >= LAT_LAST) state_d = ST_SPH_ISSUE;
      ST_SPH_ISSUE: state_d = ST_SPH_WAIT;
      ST_SPH_WAIT:  if (bus.cd_valid) state_d = sph_last ? ST_WRITE : ST_SPH_ISSUE;
      ST_WRITE:     if (bus.fb_ready) state_d = ST_ADVANCE;
      ST_ADVANCE:   state_d = pix_last ? ST_DONE : ST_RAY_WAIT;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    frame_done = (state_q == ST_DONE);
    bus.cd_req = (state_q == ST_SPH_ISSUE);
    bus.fb_we  = (state_q == ST_WRITE);
  end

  // Strict less-than lets the lower sphere index win a tie and rejects t == T_MAX.
  always_comb begin
    lat_cnt_d = lat_cnt_q;
    sph_idx_d = sph_idx_q;
    tbest_d   = tbest_q;
    hit_col_d = hit_col_q;
    if (enter_ray) begin
      lat_cnt_d = '0;
      sph_idx_d = '0;
      tbest_d   = T_MAX;
      hit_col_d = BG_COLOR;
    end else if (state_q == ST_RAY_WAIT) begin
      lat_cnt_d = lat_cnt_q + LAT_W'(1);
    end else if ((state_q == ST_SPH_WAIT) && bus.cd_valid) begin
      if (bus.cd_collide && (bus.cd_tnew < tbest_q)) begin
        tbest_d   = bus.cd_tnew;
        hit_col_d = bus.sph_col;
      end
      if (!sph_last) begin
        sph_idx_d = sph_idx_q + SIDX_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lat_cnt_q <= '0;
      sph_idx_q <= '0;
      tbest_q   <= T_MAX;
      hit_col_q <= BG_COLOR;
    end else begin
      lat_cnt_q <= lat_cnt_d;
      sph_idx_q <= sph_idx_d;
      tbest_q   <= tbest_d;
      hit_col_q <= hit_col_d;
    end
  end

  assign bus.WriteX   = pix_x;
  assign bus.WriteY   = pix_y;
  assign bus.sph_idx  = sph_idx_q;
  assign bus.cd_tbest = tbest_q;
  assign bus.fb_color = hit_col_q;

endmodule
